// File: rtl/clk_div_mon_pkg.sv
// Shared types and constants for the divided-clock monitor.
package clk_div_mon_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      LOCKED  = 2'd3
   } state_t;

   localparam logic [1:0] ERR_NONE   = 2'b00;
   localparam logic [1:0] ERR_PERIOD = 2'b01;
   localparam logic [1:0] ERR_DUTY   = 2'b10;
   localparam logic [1:0] ERR_TMO    = 2'b11;

endpackage

// File: rtl/clk_div_mon_meas.sv
// Rise detector and saturating period / high-phase counters for the divider output.
module clk_div_mon_meas #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clear,
   input  logic           div_clk,
   output logic           rise,
   output logic [WIDTH:0] cnt,
   output logic [WIDTH:0] hcnt
);

   localparam logic [WIDTH:0] SAT = '1;
   localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

   logic d1;

   assign rise = div_clk & ~d1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d1   <= 1'b0;
         cnt  <= '0;
         hcnt <= '0;
      end else begin
         d1 <= div_clk;
         if (clear) begin
            cnt  <= '0;
            hcnt <= '0;
         end else if (rise) begin
            cnt  <= ONE;
            hcnt <= ONE;
         end else begin
            if (cnt != SAT) cnt <= cnt + ONE;
            if (div_clk && (hcnt != SAT)) hcnt <= hcnt + ONE;
         end
      end
   end

endmodule

// File: rtl/clk_div_mon.sv
// Divided-clock monitor: checks divider period and duty against the programmed
// ratio, reports lock and a sticky first-error code.
module clk_div_mon
   import clk_div_mon_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int LOCK_CNT = 4
) (
   input  logic             i_clk_ref,
   input  logic             i_rst_n,
   input  logic             i_mon_en,
   input  logic [WIDTH-1:0] i_div_ratio,
   input  logic             i_div_clk,
   input  logic             i_err_clr,
   output logic [WIDTH:0]   o_period,
   output logic [WIDTH:0]   o_high,
   output logic             o_meas_valid,
   output logic             o_locked,
   output logic             o_err,
   output logic [1:0]       o_err_code,
   output state_t           o_state
);

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam logic [GW-1:0]    LOCK_TGT  = GW'(LOCK_CNT);
   localparam logic [GW-1:0]    GOOD_MAX  = '1;
   localparam logic [WIDTH-1:0] RATIO_MIN = WIDTH'(2);

   state_t           state, state_n;
   logic [WIDTH-1:0] ratio_q, ratio_n;
   logic [GW-1:0]    good_cnt, good_n;
   logic             locked_n, err_n, valid_n;
   logic [1:0]       code_n, set_code;
   logic [WIDTH:0]   period_n, high_n;
   logic             clear, err_set;
   logic             rise;
   logic [WIDTH:0]   cnt, hcnt;

   clk_div_mon_meas #(.WIDTH(WIDTH)) u_meas (
      .clk     (i_clk_ref),
      .rst_n   (i_rst_n),
      .clear   (clear),
      .div_clk (i_div_clk),
      .rise    (rise),
      .cnt     (cnt),
      .hcnt    (hcnt)
   );

   logic           active;
   logic [WIDTH:0] ratio_ext, half_lo, half_hi, tmo_lim;
   logic           period_bad, duty_bad;

   assign active     = i_mon_en && (i_div_ratio >= RATIO_MIN);
   assign ratio_ext  = {1'b0, ratio_q};
   assign half_lo    = ratio_ext >> 1;
   assign half_hi    = (ratio_ext + 1'b1) >> 1;
   assign tmo_lim    = {ratio_q, 1'b0};
   assign period_bad = (cnt != ratio_ext);
   assign duty_bad   = (hcnt != half_lo) && (hcnt != half_hi);
   assign o_state    = state;

   // Priority: inactive > arming from IDLE > ratio change > rise > timeout.
   always_comb begin
      state_n  = state;
      ratio_n  = ratio_q;
      good_n   = good_cnt;
      locked_n = o_locked;
      period_n = o_period;
      high_n   = o_high;
      valid_n  = 1'b0;
      clear    = 1'b0;
      err_set  = 1'b0;
      set_code = ERR_NONE;

      if (!active) begin
         state_n  = IDLE;
         locked_n = 1'b0;
         good_n   = '0;
         clear    = 1'b1;
      end else if (state == IDLE) begin
         state_n = ARM;
         ratio_n = i_div_ratio;
         clear   = 1'b1;
      end else if (i_div_ratio != ratio_q) begin
         state_n  = ARM;
         ratio_n  = i_div_ratio;
         locked_n = 1'b0;
         good_n   = '0;
         clear    = 1'b1;
      end else if (rise) begin
         if (state == ARM) begin
            state_n = MEASURE;
         end else begin
            valid_n  = 1'b1;
            period_n = cnt;
            high_n   = hcnt;
            if (period_bad || duty_bad) begin
               state_n  = MEASURE;
               locked_n = 1'b0;
               good_n   = '0;
               err_set  = 1'b1;
               set_code = period_bad ? ERR_PERIOD : ERR_DUTY;
            end else begin
               if (good_cnt != GOOD_MAX) good_n = good_cnt + 1'b1;
               if (good_n >= LOCK_TGT) begin
                  state_n  = LOCKED;
                  locked_n = 1'b1;
               end
            end
         end
      end else if (cnt >= tmo_lim) begin
         state_n  = ARM;
         locked_n = 1'b0;
         good_n   = '0;
         clear    = 1'b1;
         err_set  = 1'b1;
         set_code = ERR_TMO;
      end

      // A new error beats a simultaneous clear; otherwise the first code sticks.
      err_n  = o_err;
      code_n = o_err_code;
      if (err_set && (!o_err || i_err_clr)) begin
         err_n  = 1'b1;
         code_n = set_code;
      end else if (i_err_clr) begin
         err_n  = 1'b0;
         code_n = ERR_NONE;
      end
   end

   always_ff @(posedge i_clk_ref or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         ratio_q      <= '0;
         good_cnt     <= '0;
         o_locked     <= 1'b0;
         o_err        <= 1'b0;
         o_err_code   <= ERR_NONE;
         o_period     <= '0;
         o_high       <= '0;
         o_meas_valid <= 1'b0;
      end else begin
         state        <= state_n;
         ratio_q      <= ratio_n;
         good_cnt     <= good_n;
         o_locked     <= locked_n;
         o_err        <= err_n;
         o_err_code   <= code_n;
         o_period     <= period_n;
         o_high       <= high_n;
         o_meas_valid <= valid_n;
      end
   end

endmodule
